// File: rtl/regbank_scan.sv
// 32 x DATA_W register bank exposed on a flat bus, plus a scan sequencer that
// drives the downstream 32:1 selector (sel_o/en_o). Optional macro: ZERO_REG_EN.
module regbank_scan #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 50_000_000,
  parameter int CNT_W      = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [4:0]             wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  output logic [32*DATA_W-1:0]   q_flat,
  output logic [4:0]             sel_o,
  output logic                   en_o,
  output logic                   wrap_o,
  output logic [1:0]             dbg_state_o,
  output logic [CNT_W-1:0]       dbg_presc_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(DIV_CYCLES - 1);

  // Control handshake: start/stop/step are plain levels sampled on every
  // rising edge with priority stop > start > step; there is no ready/ack.
  state_e             state_q, state_d;
  logic [4:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic               wrap_q, wrap_d;
  logic               adv;
  logic [DATA_W-1:0]  mem_q [32];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (start) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_PAUSE;
          adv     = 1'b1;
        end
      end
      ST_RUN: begin
        // Step is ignored here; stop freezes the prescaler at its current count.
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          adv     = 1'b1;
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (start) begin
          state_d = ST_RUN;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sel_d  = adv ? (sel_q + 5'd1) : sel_q;
    wrap_d = adv && (sel_q == 5'd31);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
`ifdef ZERO_REG_EN
    end else if (wr_en && (wr_addr != 5'd0)) begin
`else
    end else if (wr_en) begin
`endif
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_flat
`ifdef ZERO_REG_EN
    if (g == 0) begin : g_zero
      assign q_flat[g*DATA_W +: DATA_W] = '0;
    end else begin : g_word
      assign q_flat[g*DATA_W +: DATA_W] = mem_q[g];
    end
`else
    assign q_flat[g*DATA_W +: DATA_W] = mem_q[g];
`endif
  end

  assign sel_o       = sel_q;
  assign en_o        = (state_q != ST_IDLE);
  assign wrap_o      = wrap_q;
  assign dbg_state_o = state_q;
  assign dbg_presc_o = presc_q;

endmodule

// File: tb/tb_regbank_scan.sv
// Directed bench for regbank_scan with DIV_CYCLES=4: vector table for the scan
// FSM plus hand-written sequences for wrap, async reset and word-0 handling.
module tb_regbank_scan;

  localparam int DW    = 32;
  localparam int DIV   = 4;
  localparam int CW    = 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [4:0]      wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            step = 1'b0;
  logic [32*DW-1:0] q_flat;
  logic [4:0]      sel_o;
  logic            en_o;
  logic            wrap_o;
  logic [1:0]      dbg_state_o;
  logic [CW-1:0]   dbg_presc_o;

  regbank_scan #(.DATA_W(DW), .DIV_CYCLES(DIV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .step(step), .q_flat(q_flat), .sel_o(sel_o),
    .en_o(en_o), .wrap_o(wrap_o), .dbg_state_o(dbg_state_o), .dbg_presc_o(dbg_presc_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int              n_chk = 0;
  int              n_err = 0;
  logic [DW-1:0]   exp_mem [32];
  logic [DW-1:0]   exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_words(input string tag);
    logic [DW-1:0] e;
    for (int i = 0; i < 32; i++) exp_q.push_back(exp_mem[i]);
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s word%0d", tag, i), q_flat[i*DW +: DW], e);
    end
  endtask

  task automatic chk_fsm(input string tag, input logic [1:0] st, input logic [4:0] sel,
                         input logic en, input logic wrap, input logic [CW-1:0] p);
    chk({tag, " state"}, 32'(dbg_state_o), 32'(st));
    chk({tag, " sel"},   32'(sel_o),       32'(sel));
    chk({tag, " en"},    32'(en_o),        32'(en));
    chk({tag, " wrap"},  32'(wrap_o),      32'(wrap));
    chk({tag, " presc"}, 32'(dbg_presc_o), 32'(p));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic sp, input logic stp);
    start = s; stop = sp; step = stp;
    tick();
    start = 1'b0; stop = 1'b0; step = 1'b0;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
`ifdef ZERO_REG_EN
    if (a != 5'd0) exp_mem[a] = d;
`else
    exp_mem[a] = d;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            start, stop, step;
    logic [1:0]      st;
    logic [4:0]      sel;
    logic            en, wrap;
    logic [CW-1:0]   presc;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input int s, input int sp, input int stp, input logic [1:0] st,
                              input int sel, input int en, input int p);
    vec_t v;
    logic [31:0] t;
    t = 32'(s);   v.start = t[0];
    t = 32'(sp);  v.stop  = t[0];
    t = 32'(stp); v.step  = t[0];
    v.st = st;
    t = 32'(sel); v.sel = t[4:0];
    t = 32'(en);  v.en  = t[0];
    v.wrap = 1'b0;
    t = 32'(p);   v.presc = t[CW-1:0];
    return v;
  endfunction

  initial begin
    int wcnt;
    // Starting point of the table: IDLE, sel=0, prescaler=0.
    tbl[0]  = mk(1,0,0, S_RUN,   0,1,0);
    tbl[1]  = mk(0,0,0, S_RUN,   0,1,1);
    tbl[2]  = mk(0,0,0, S_RUN,   0,1,2);
    tbl[3]  = mk(0,0,0, S_RUN,   0,1,3);
    tbl[4]  = mk(0,0,0, S_RUN,   1,1,0);
    tbl[5]  = mk(0,0,0, S_RUN,   1,1,1);
    tbl[6]  = mk(0,0,0, S_RUN,   1,1,2);
    tbl[7]  = mk(0,0,0, S_RUN,   1,1,3);
    tbl[8]  = mk(0,0,0, S_RUN,   2,1,0);
    tbl[9]  = mk(0,0,1, S_RUN,   2,1,1);   // step ignored in RUN
    tbl[10] = mk(0,1,0, S_PAUSE, 2,1,1);   // stop holds prescaler
    tbl[11] = mk(0,0,1, S_PAUSE, 3,1,1);
    tbl[12] = mk(0,0,0, S_PAUSE, 3,1,1);
    tbl[13] = mk(0,0,1, S_PAUSE, 4,1,1);
    tbl[14] = mk(0,0,0, S_PAUSE, 4,1,1);
    tbl[15] = mk(0,0,1, S_PAUSE, 5,1,1);
    tbl[16] = mk(1,1,0, S_PAUSE, 5,1,1);   // start+stop: stop wins
    tbl[17] = mk(1,0,1, S_RUN,   5,1,1);   // start beats step, prescaler resumes
    tbl[18] = mk(0,0,0, S_RUN,   5,1,2);
    tbl[19] = mk(0,0,0, S_RUN,   5,1,3);
    tbl[20] = mk(0,0,0, S_RUN,   6,1,0);

    for (int i = 0; i < 32; i++) exp_mem[i] = '0;

    // Reset state while rst is still high, before any clock edge.
    #2;
    chk_fsm("por", S_IDLE, 5'd0, 1'b0, 1'b0, '0);
    chk_words("por");
    tick();
    rst = 1'b0;
    tick();

    // Single write lands one cycle later and touches only its own word.
    write_word(5'd5, 32'hDEAD_BEEF);
    chk_words("wr5");
    write_word(5'd31, 32'hA5A5_5A5A);
    chk_words("wr31");
    chk_fsm("idle_after_wr", S_IDLE, 5'd0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].step);
      chk_fsm($sformatf("vec%0d", i), tbl[i].st, tbl[i].sel, tbl[i].en, tbl[i].wrap, tbl[i].presc);
    end

    // Wrap: park at 31 by stepping, then let RUN carry it over.
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      tick();
    end
    chk_fsm("at31", S_PAUSE, 5'd31, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0);
    chk_fsm("run31", S_RUN, 5'd31, 1'b1, 1'b0, '0);
    wcnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (wrap_o === 1'b1) wcnt++;
      if (c == 4) chk_fsm("wrap_edge", S_RUN, 5'd0, 1'b1, 1'b1, '0);
      if (c == 5) chk("wrap_drop", 32'(wrap_o), 32'd0);
    end
    chk("wrap_count", 32'(wcnt), 32'd1);
    chk("sel_after_wrap", 32'(sel_o), 32'd1);

    // Async reset mid-RUN with sel=7.
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0);
    tick();
    chk_fsm("pre_rst", S_RUN, 5'd7, 1'b1, 1'b0, 3'd1);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    chk_fsm("async_rst", S_IDLE, 5'd0, 1'b0, 1'b0, '0);
    chk_words("async_rst");
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk_fsm("post_rst", S_IDLE, 5'd0, 1'b0, 1'b0, '0);

    // IDLE step moves to PAUSE and increments on the same edge.
    drive(1'b0, 1'b0, 1'b1);
    chk_fsm("idle_step", S_PAUSE, 5'd1, 1'b1, 1'b0, '0);

    // IDLE start+stop goes to PAUSE without an increment.
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    chk_fsm("idle_startstop", S_PAUSE, 5'd0, 1'b1, 1'b0, '0);

    // Word 0 write: ordinary register unless ZERO_REG_EN is defined.
    write_word(5'd0, 32'h0000_1234);
`ifdef ZERO_REG_EN
    chk("word0", q_flat[31:0], 32'h0);
`else
    chk("word0", q_flat[31:0], 32'h0000_1234);
`endif
    chk_words("wr0");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
